muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the 8051 MUL AB / DIV AB instructions, the operations the processing stage routes through its special op code (alu_op = 4'hF) instead of the single-cycle ALU.
- Captures A, B and PSW on a start pulse and runs 8 iterations: shift-add for multiply, restoring division for divide.
- Returns A/B results and an updated PSW with a one-cycle done pulse. The control unit stalls on busy.

Parameters:
- DATA_W, 8, operand width; the iteration count equals DATA_W.
- PSW_CY, 7, bit index of CY in PSW.
- PSW_OV, 2, bit index of OV in PSW.
- PSW_P, 0, bit index of parity flag P in PSW.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- op_div  input  1  0 = MUL AB, 1 = DIV AB; captured with start.
- a_data  input  DATA_W  accumulator operand.
- b_data  input  DATA_W  B-register operand.
- psw_in  input  8  current PSW; captured with start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; results are valid from this cycle on.
- ans_a  output  DATA_W  result for A (product low byte or quotient).
- ans_b  output  DATA_W  result for B (product high byte or remainder).
- psw_out  output  8  updated PSW.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state = IDLE, busy = 0, done = 0, ans_a = 0, ans_b = 0, psw_out = 0, iteration counter = 0. Reset mid-operation aborts immediately: no done pulse, results cleared.
- States: IDLE, CALC, DONE.
- IDLE: when start = 1 at edge 0, capture the operands, op_div and psw_in.
  - If op_div = 1 and b_data = 0, go directly to DONE.
  - Otherwise go to CALC with counter = 0.
- CALC: one iteration per edge for edges 1..8. After the edge where the counter reaches DATA_W-1, go to DONE.
- DONE: done = 1 for exactly one cycle; next edge returns to IDLE.
  - Normal latency: done is high between edge 8 and edge 9.
  - Divide-by-zero latency: done is high between edge 0 and edge 1.
- ans_a, ans_b and psw_out are registered. They update on the edge entering DONE and hold until the next operation's DONE or reset.
- start while busy = 1 is ignored and not queued. start in the DONE cycle is also ignored. A new start is accepted in the first IDLE cycle after DONE.
- MUL: 16-bit product of unsigned operands.
  - ans_a = product[7:0], ans_b = product[15:8].
  - OV = 1 if product > 8'hFF, else 0.
- DIV: unsigned quotient and remainder.
  - ans_a = quotient, ans_b = remainder, OV = 0.
- Divide-by-zero: ans_a = 8'hFF, ans_b = captured a_data, OV = 1.
- All operations:
  - CY = 0.
  - P = XOR-reduction of ans_a (even parity; P = 1 for an odd count of ones).
  - All other PSW bits pass through unchanged from the captured psw_in.
- Operand inputs are ignored after capture; they may change freely during CALC.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE / CALC / DONE);
  - the PSW bit indices CY, AC, F0, RS1, RS0, OV, F1, P;
  - the special ALU op constant 4'hF used by the processing stage to select this block's result.
- One natural sub-module, muldiv_core: the single-iteration datapath (shift-add step and restore-subtract step), purely combinational. muldiv_seq owns the FSM, counter and registers.

Test Plan:
- MUL overflow: a = 0x50, b = 0xA0, psw_in = 0x85 → done after 8 cycles; ans_a = 0x00, ans_b = 0x32, psw_out = 0x04 (CY = 0, OV = 1, P = 0).
- MUL no overflow: a = 0x0C, b = 0x0A, psw_in = 0x00 → ans_a = 0x78, ans_b = 0x00, OV = 0, P = 0, psw_out = 0x00.
- DIV: a = 0xFB, b = 0x12, psw_in = 0x18 → ans_a = 0x0D, ans_b = 0x11, psw_out = 0x19 (RS bits preserved, P = 1).
- DIV by zero: a = 0x25, b = 0x00 → done one cycle after start; ans_a = 0xFF, ans_b = 0x25, OV = 1, CY = 0, P = 0.
- start re-asserted on cycles 3 and 8 of an operation → ignored; exactly one done pulse, results unchanged. start on the first IDLE cycle afterward → accepted.
- rst asserted at cycle 4 of CALC → next cycle: busy = 0, done = 0, all outputs 0. A following MUL 0x03 × 0x05 completes normally with ans_a = 0x0F.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared state encoding, PSW bit indices and the special ALU op code
package muldiv_seq_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int PSW_BIT_CY  = 7;
  localparam int PSW_BIT_AC  = 6;
  localparam int PSW_BIT_F0  = 5;
  localparam int PSW_BIT_RS1 = 4;
  localparam int PSW_BIT_RS0 = 3;
  localparam int PSW_BIT_OV  = 2;
  localparam int PSW_BIT_F1  = 1;
  localparam int PSW_BIT_P   = 0;
  localparam logic [3:0] ALU_OP_MULDIV = 4'hF;
endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: one combinational shift-add (MUL) or restore-subtract (DIV) iteration
module muldiv_core
  import muldiv_seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              op_div,
  input  logic [DATA_W-1:0] hi,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] hi_nx,
  output logic [DATA_W-1:0] lo_nx
);
  logic [DATA_W:0] sum, sh, diff;
  always_comb begin
    sum   = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    sh    = {hi, lo[DATA_W-1]};
    diff  = sh - {1'b0, b};
    hi_nx = op_div ? (diff[DATA_W] ? sh[DATA_W-1:0] : diff[DATA_W-1:0]) : sum[DATA_W:1];
    lo_nx = op_div ? {lo[DATA_W-2:0], ~diff[DATA_W]} : {sum[0], lo[DATA_W-1:1]};
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle 8051 MUL AB / DIV AB sequencer with PSW update
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PSW_CY = PSW_BIT_CY,
  parameter int PSW_OV = PSW_BIT_OV,
  parameter int PSW_P  = PSW_BIT_P
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op_div,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  input  logic [7:0]        psw_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] ans_a,
  output logic [DATA_W-1:0] ans_b,
  output logic [7:0]        psw_out
);
  localparam int CW = $clog2(DATA_W);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] hi, lo, b_q, hi_nx, lo_nx, res_a, res_b;
  logic div_q, dz, last, ld, ov;
  logic [7:0] psw_q, psw_new;
  muldiv_core #(.DATA_W(DATA_W)) u_core (
    .op_div(div_q),
    .hi    (hi),
    .lo    (lo),
    .b     (b_q),
    .hi_nx (hi_nx),
    .lo_nx (lo_nx)
  );
  always_comb begin
    dz       = start && op_div && b_data == '0;
    last     = cnt == CW'(DATA_W - 1);
    state_nx = state == IDLE ? (start ? (dz ? DONE : CALC) : IDLE) :
               state == CALC ? (last ? DONE : CALC) : IDLE;
    ld       = state == IDLE ? dz : state == CALC && last;
    res_a    = state == IDLE ? '1 : lo_nx;
    res_b    = state == IDLE ? a_data : hi_nx;
    ov       = state == IDLE ? 1'b1 : ~div_q && |hi_nx;
    psw_new  = state == IDLE ? psw_in : psw_q;
    psw_new[PSW_CY] = 1'b0;
    psw_new[PSW_OV] = ov;
    psw_new[PSW_P]  = ^res_a;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      psw_q   <= '0;
      ans_a   <= '0;
      ans_b   <= '0;
      psw_out <= '0;
    end else begin
      if (state == IDLE && start) begin
        cnt   <= '0;
        hi    <= '0;
        lo    <= a_data;
        b_q   <= b_data;
        div_q <= op_div;
        psw_q <= psw_in;
      end else if (state == CALC) begin
        cnt <= cnt + CW'(1);
        hi  <= hi_nx;
        lo  <= lo_nx;
      end
      if (ld) begin
        ans_a   <= res_a;
        ans_b   <= res_b;
        psw_out <= psw_new;
      end
    end
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule
